heap_array_allocator: RTL
=========================

Name: heap_array_allocator

Overview:
- Hardware array allocator feeding the generated-program fpga test harness.
- Hands out array handles from a freed-arrays stack, else from a fresh-allocation counter.
- Accepts frees and tracks per-array length with the grow-only `index+1` rule.
- Replaces the inline `array`/`free` bookkeeping so the program stage only issues requests and consumes handles.

Parameters:
- MemoryElementWidth, 12, width of handles, indices and sizes.
- NArrays, 4, maximum number of arrays; valid handles are 0..NArrays-1.
- NArea, 4, maximum array length; sizes saturate at NArea.

Ports:
- clock  input  1  single clock, all state changes on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- ready  output 1  high in IDLE; requests are ignored while low.
- allocReq  input  1  level request for a new array.
- allocAck  output 1  one-cycle pulse; allocArray is valid in the same cycle.
- allocFail  output 1  one-cycle pulse; no array is available.
- allocArray  output MemoryElementWidth  allocated handle; holds its value until the next alloc.
- freeReq  input  1  level request to free freeArray.
- freeArray  input  MemoryElementWidth  handle to free.
- freeAck  output 1  one-cycle pulse; free accepted.
- freeFail  output 1  one-cycle pulse; handle is out of range or not allocated.
- sizeWrite  input  1  length update strobe.
- sizeArray  input  MemoryElementWidth  array being written.
- sizeIndex  input  MemoryElementWidth  element index written.
- sizeRdArray  input  MemoryElementWidth  array whose size is read.
- sizeRdData  output MemoryElementWidth  size of sizeRdArray, registered with 1-cycle latency.
- inUse  output MemoryElementWidth  count of currently allocated arrays.
- allocs  output MemoryElementWidth  high-water mark: handles ever issued fresh.

Behaviour:
- Reset state:
  - All outputs 0.
  - freedTop = 0, allocs = 0, allocated bitmap = 0.
  - FSM enters INIT.
- INIT:
  - Zeroes arraySizes[0..NArrays-1], one entry per cycle.
  - Takes NArrays cycles, then goes to IDLE with ready = 1.
  - Reset asserted mid-INIT restarts INIT from entry 0.
- IDLE: on each posedge, at most one of alloc or free is serviced.
  - Alloc has priority over free.
  - A blocked free gets no ack and must stay asserted; it is serviced on a following cycle.
- Alloc sequence (allocReq high in IDLE):
  - If freedTop > 0: pop freedArrays[freedTop-1].
  - Else if allocs < NArrays: take handle = allocs, then allocs = allocs + 1.
  - Else: pulse allocFail next cycle; no state change.
  - On success: set the bitmap bit, set arraySizes[handle] = 0, inUse + 1, pulse allocAck next cycle with allocArray = handle.
  - FSM goes to RESP for one cycle (ready = 0), then back to IDLE.
  - Requester must drop allocReq on ack or fail, otherwise a second alloc follows.
- Free sequence:
  - If freeArray >= allocs or its bitmap bit is 0: pulse freeFail; no change.
  - Else: push onto freedArrays, clear the bit, inUse - 1, pulse freeAck.
  - Same RESP timing as alloc.
  - The stack cannot overflow because a double free is rejected.
- Size write (evaluated every IDLE cycle, independent of alloc/free):
  - Ignored if sizeArray is not allocated.
  - If arraySizes[sizeArray] < sizeIndex + 1, set it to min(sizeIndex + 1, NArea).
  - Compare in MemoryElementWidth+1 bits so sizeIndex = all-ones does not wrap.
  - If it targets the handle being allocated in the same cycle, the alloc zeroing wins.
- Size read:
  - sizeRdData <= arraySizes[sizeRdArray] every cycle.
  - An out-of-range sizeRdArray returns 0.
  - A read in the cycle after a write returns the updated value.
- LIFO reuse: the most recently freed handle is the next one issued, matching program-visible handle numbering.

Test Plan:
- Reset, wait 4 cycles (INIT) -> ready = 1; alloc x4 -> handles 0,1,2,3, allocs = 4, inUse = 4; fifth alloc -> allocFail, no state change.
- Free 2, free 0, then alloc x2 -> handles 0 then 2 (LIFO), allocs stays 4.
- Free 1 twice -> first freeAck, second freeFail; free 7 -> freeFail; inUse decrements only once.
- Alloc 0, sizeWrite index 2 -> size 3; index 0 -> size stays 3; index 9 -> size 4 (saturated); re-free and re-alloc 0 -> size reads 0.
- allocReq and freeReq both high -> alloc acked first, free acked on the next service cycle.
- Reset asserted during RESP and during INIT cycle 2 -> all outputs 0 immediately; INIT reruns for 4 cycles; no stale ack.

Source files
------------

// File: rtl/heap_array_allocator.sv
// Array handle allocator: LIFO reuse of freed handles, fresh handles from a counter,
// and grow-only per-array length tracking with saturating size writes.
module heap_array_allocator #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 4,
  parameter int NArea              = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic                          ready,
  input  logic                          allocReq,
  output logic                          allocAck,
  output logic                          allocFail,
  output logic [MemoryElementWidth-1:0] allocArray,
  input  logic                          freeReq,
  input  logic [MemoryElementWidth-1:0] freeArray,
  output logic                          freeAck,
  output logic                          freeFail,
  input  logic                          sizeWrite,
  input  logic [MemoryElementWidth-1:0] sizeArray,
  input  logic [MemoryElementWidth-1:0] sizeIndex,
  input  logic [MemoryElementWidth-1:0] sizeRdArray,
  output logic [MemoryElementWidth-1:0] sizeRdData,
  output logic [MemoryElementWidth-1:0] inUse,
  output logic [MemoryElementWidth-1:0] allocs,
  output logic [1:0]                    dbg_state
);
  localparam int MW = MemoryElementWidth;
  localparam int AW = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam logic [MW-1:0] N_ARR  = MW'(NArrays);
  localparam logic [MW:0]   N_AREA = (MW+1)'(NArea);

  // Handshake: every request is a level held while ready is high; the allocator
  // answers with exactly one ack or fail pulse during the following RESP cycle.
  typedef enum logic [1:0] {S_INIT = 2'd0, S_IDLE = 2'd1, S_RESP = 2'd2} state_t;
  state_t state, state_nxt;

  logic [AW-1:0]      init_idx;
  logic [MW-1:0]      freed_top;
  logic [MW-1:0]      freed_arrays [NArrays];
  logic [MW-1:0]      array_sizes  [NArrays];
  logic [NArrays-1:0] bitmap;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: if (init_idx == AW'(NArrays - 1)) state_nxt = S_IDLE;
      S_IDLE: if (allocReq || freeReq) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    ready     = (state == S_IDLE);
    dbg_state = state;
  end

  // Size-write evaluation, done in MW+1 bits so an all-ones index cannot wrap.
  logic          wr_hit;
  logic [MW:0]   wr_want;
  logic [MW:0]   wr_cur;
  logic [MW-1:0] wr_val;
  always_comb begin
    wr_hit  = 1'b0;
    wr_cur  = '0;
    wr_want = {1'b0, sizeIndex} + (MW+1)'(1);
    wr_val  = (wr_want > N_AREA) ? N_AREA[MW-1:0] : wr_want[MW-1:0];
    if (sizeWrite && sizeArray < N_ARR && bitmap[sizeArray[AW-1:0]]) begin
      wr_cur = {1'b0, array_sizes[sizeArray[AW-1:0]]};
      wr_hit = (wr_cur < wr_want);
    end
  end

  logic          can_pop, can_fresh, free_ok;
  logic [MW-1:0] pop_handle;
  always_comb begin
    can_pop    = (freed_top != '0);
    can_fresh  = (allocs < N_ARR);
    pop_handle = freed_arrays[AW'(freed_top - MW'(1))];
    free_ok    = (freeArray < allocs) && bitmap[freeArray[AW-1:0]];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      init_idx   <= '0;
      freed_top  <= '0;
      bitmap     <= '0;
      allocs     <= '0;
      inUse      <= '0;
      allocAck   <= 1'b0;
      allocFail  <= 1'b0;
      allocArray <= '0;
      freeAck    <= 1'b0;
      freeFail   <= 1'b0;
      sizeRdData <= '0;
      for (int i = 0; i < NArrays; i++) begin
        freed_arrays[i] <= '0;
        array_sizes[i]  <= '0;
      end
    end else begin
      allocAck  <= 1'b0;
      allocFail <= 1'b0;
      freeAck   <= 1'b0;
      freeFail  <= 1'b0;
      sizeRdData <= (sizeRdArray < N_ARR) ? array_sizes[sizeRdArray[AW-1:0]] : '0;

      if (state == S_INIT) begin
        array_sizes[init_idx] <= '0;
        init_idx <= init_idx + AW'(1);
      end

      if (state == S_IDLE) begin
        if (wr_hit) array_sizes[sizeArray[AW-1:0]] <= wr_val;
        // Alloc comes after the size write so its zeroing wins on the same handle.
        if (allocReq) begin
          if (can_pop || can_fresh) begin
            if (can_pop) begin
              allocArray <= pop_handle;
              bitmap[pop_handle[AW-1:0]]      <= 1'b1;
              array_sizes[pop_handle[AW-1:0]] <= '0;
              freed_top <= freed_top - MW'(1);
            end else begin
              allocArray <= allocs;
              bitmap[allocs[AW-1:0]]      <= 1'b1;
              array_sizes[allocs[AW-1:0]] <= '0;
              allocs <= allocs + MW'(1);
            end
            inUse    <= inUse + MW'(1);
            allocAck <= 1'b1;
          end else begin
            allocFail <= 1'b1;
          end
        end else if (freeReq) begin
          if (free_ok) begin
            freed_arrays[freed_top[AW-1:0]] <= freeArray;
            freed_top <= freed_top + MW'(1);
            bitmap[freeArray[AW-1:0]] <= 1'b0;
            inUse   <= inUse - MW'(1);
            freeAck <= 1'b1;
          end else begin
            freeFail <= 1'b1;
          end
        end
      end
    end
  end
endmodule
